// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
package gate_check_pkg;

  // Checker sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned N_VECTORS = 4;
  localparam int unsigned IDX_W     = 2;

  // Truth tables indexed by {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  // Counter width able to hold cycles-1 (at least one bit).
  function automatic int unsigned settle_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// settle_timer: load / count-down / expire counter that paces each DRIVE phase.
module settle_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired_c
);

  logic [WIDTH-1:0] count;

  // Load on request, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: drives all four {a,b} vectors into an external
// 2-input gate, compares o against the EXPECTED truth table and reports the
// result. Optional mismatch counter port enabled by GATE_CHECK_ERR_CNT_EN.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  EXPECTED      = TT_AND
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_index
`ifdef GATE_CHECK_ERR_CNT_EN
  ,
  output logic [2:0] err_cnt
`endif
);

  localparam int unsigned     CNT_W       = settle_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_VECTORS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             timer_load_c;
  logic             settle_expired_c;

  // Restart the settle window whenever a vector is (re)applied.
  assign timer_load_c = ((state == IDLE) && start) ||
                        ((state == SAMPLE) && (idx != IDX_LAST));

  settle_timer #(
    .WIDTH (CNT_W)
  ) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load_c),
    .load_val  (SETTLE_LOAD),
    .expired_c (settle_expired_c)
  );

  // Sequencer with registered outputs; pass doubles as "no mismatch yet".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_index <= 2'b00;
`ifdef GATE_CHECK_ERR_CNT_EN
      err_cnt    <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= DRIVE;
            idx        <= '0;
            {a, b}     <= 2'b00;
            busy       <= 1'b1;
            pass       <= 1'b1;
            fail_index <= 2'b00;
`ifdef GATE_CHECK_ERR_CNT_EN
            err_cnt    <= 3'd0;
`endif
          end
        end
        DRIVE: begin
          if (settle_expired_c) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (o !== EXPECTED[idx]) begin
            pass <= 1'b0;
            if (pass) begin
              fail_index <= idx;
            end
`ifdef GATE_CHECK_ERR_CNT_EN
            if (err_cnt != 3'd4) begin
              err_cnt <= err_cnt + 3'd1;
            end
`endif
          end
          if (idx != IDX_LAST) begin
            idx    <= idx + IDX_W'(1);
            {a, b} <= idx + IDX_W'(1);
            state  <= DRIVE;
          end else begin
            {a, b} <= 2'b00;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gate_truth_table_checker.md
GATE_TRUTH_TABLE_CHECKER -- requirements
Module: gate_truth_table_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: cycles the operand pair is held before sampling o; legal range 1..15.
REQ-002 Parameter EXPECTED, default 4'b1000 (AND): 4-bit truth table; bit {a,b} is the expected o.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a check run; sampled only in IDLE.
REQ-006 a, b  output  1 each  operands driven into the downstream 2-input gate under test.
REQ-007 o  input  1  gate-under-test output.
REQ-008 busy  output  1  high while a run is in progress (states DRIVE and SAMPLE).
REQ-009 done  output  1  single-cycle pulse at run completion.
REQ-010 pass  output  1  run result; valid from the done cycle until the next accepted start.
REQ-011 fail_index  output  2  {a,b} of the first mismatching vector; 2'b00 when pass=1.
REQ-012 err_cnt  output  3  mismatch count, 0..4; present only under GATE_CHECK_ERR_CNT_EN.

Function
REQ-013 FSM states: IDLE, DRIVE, SAMPLE, DONE; encoding comes from the package enum.
REQ-014 IDLE with start=1 -> DRIVE; the state clears idx, pass<=1, fail_index<=0 and err_cnt<=0.
REQ-015 start in any state other than IDLE is ignored, with no side effects.
REQ-016 {a,b} shall equal idx during DRIVE and SAMPLE, and 2'b00 in IDLE and DONE.
REQ-017 DRIVE lasts exactly SETTLE_CYCLES cycles via the settle counter, then -> SAMPLE.
REQ-018 SAMPLE, one cycle: if o differs from EXPECTED[idx], the block clears pass, increments err_cnt, and writes fail_index only if this is the first mismatch.
REQ-019 In simulation, X or Z on o counts as a mismatch; the comparison uses case inequality.
REQ-020 SAMPLE with idx!=3 increments idx and goes -> DRIVE; SAMPLE with idx==3 goes -> DONE, with no idx wrap to 0 during the run.
REQ-021 DONE lasts one cycle with done=1, then -> IDLE; start in DONE is ignored.
REQ-022 Latency: done is high exactly 4*(SETTLE_CYCLES+1)+1 cycles after the rising edge that accepted start.
REQ-023 pass, fail_index and err_cnt hold their values in IDLE until the next accepted start.

Reset
REQ-024 rst_n=0 immediately forces: state=IDLE, idx=0, a=b=0, busy=0, done=0, pass=0, fail_index=0, err_cnt=0.
REQ-025 Reset mid-run aborts the run, with no done pulse and no partial result retained.
REQ-026 Release of rst_n needs no synchronizer inside the block; the system provides a synchronous deassertion.

Configuration
REQ-027 Macro GATE_CHECK_ERR_CNT_EN defined: the err_cnt port and its counter exist, and the counter saturates at 4.
REQ-028 Macro undefined: the err_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 Package gate_check_pkg shall hold:
- state enum typedef
- N_VECTORS=4
- truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111
REQ-030 One sub-module, settle_timer, is natural: a load/count-down/expire counter with width sized for SETTLE_CYCLES.
REQ-031 The gate under test is instantiated outside this block; the bench connects a, b and o.

Verification
REQ-032 Mux-based AND gate, EXPECTED=TT_AND, SETTLE_CYCLES=1, start pulse -> done at cycle 9, pass=1, fail_index=0, err_cnt=0.
REQ-033 o tied 0, EXPECTED=TT_AND -> pass=0, fail_index=2'b11, err_cnt=1.
REQ-034 o tied 1, EXPECTED=TT_AND -> pass=0, fail_index=2'b00, err_cnt=3; an OR gate with EXPECTED=TT_OR -> pass=1.
REQ-035 SETTLE_CYCLES=3, start held high for 20 cycles -> done at cycle 17, busy high 16 cycles, and a second run starts only when start is seen in IDLE after DONE.
REQ-036 rst_n pulsed low during the third vector -> all outputs 0 immediately, no done pulse; a new start then gives a full 9-cycle run with correct pass.
